// File: rtl/score_digit_driver.sv
// Two-digit BCD score keeper and on-screen glyph placement for the number bitmap renderer.
// Keeps a saturating 00..99 score, latches the shown digits once per frame, and produces
// registered inside-box flags and box-relative offsets for the tens and units glyphs.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks the tens glyph while it shows 0.
module score_digit_driver #(
    parameter int unsigned TOP_LEFT_X = 560,
    parameter int unsigned TOP_LEFT_Y = 16,
    parameter int unsigned DIGIT_W    = 16,
    parameter int unsigned DIGIT_H    = 32,
    parameter int unsigned DIGIT_GAP  = 4
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        addPulse,
    input  logic [3:0]  addValue,
    input  logic        subPulse,
    input  logic        clearScore,
    output logic        InsideRectangle1,
    output logic        InsideRectangle2,
    output logic [10:0] offsetX1,
    output logic [10:0] offsetY1,
    output logic [10:0] offsetX2,
    output logic [10:0] offsetY2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic        scoreMax
);

    // Box edges; right/bottom bounds are exclusive.
    localparam logic [10:0] X1_LO = 11'(TOP_LEFT_X);
    localparam logic [10:0] X1_HI = 11'(TOP_LEFT_X + DIGIT_W);
    localparam logic [10:0] X2_LO = 11'(TOP_LEFT_X + DIGIT_W + DIGIT_GAP);
    localparam logic [10:0] X2_HI = 11'(TOP_LEFT_X + DIGIT_W + DIGIT_GAP + DIGIT_W);
    localparam logic [10:0] Y_LO  = 11'(TOP_LEFT_Y);
    localparam logic [10:0] Y_HI  = 11'(TOP_LEFT_Y + DIGIT_H);

    // Score state
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  units_q, units_d;
    logic        max_q, max_d;

    // Display latch
    logic [3:0]  digit1_q, digit1_d;
    logic [3:0]  digit2_q, digit2_d;

    // Geometry pipeline stage
    logic        flag1_q, flag1_d;
    logic        flag2_q, flag2_d;
    logic [10:0] ox1_q, ox1_d;
    logic [10:0] oy1_q, oy1_d;
    logic [10:0] ox2_q, ox2_d;
    logic [10:0] oy2_q, oy2_d;

    // Add-path intermediates, 5 bits wide so a sum above 15 cannot wrap.
    logic [4:0]  add_v;
    logic [4:0]  units_sum;
    logic [4:0]  tens_sum;
    logic        carry;
    logic [3:0]  units_add;

    logic        in_box1;
    logic        in_box2;

    // Next score: clear beats add, add beats sub.
    always_comb begin
        tens_d    = tens_q;
        units_d   = units_q;
        max_d     = max_q;
        add_v     = (addValue > 4'd9) ? 5'd9 : {1'b0, addValue};
        units_sum = {1'b0, units_q} + add_v;
        carry     = 1'b0;
        units_add = units_sum[3:0];
        if (units_sum > 5'd9) begin
            units_add = 4'(units_sum - 5'd10);
            carry     = 1'b1;
        end
        tens_sum  = {1'b0, tens_q} + {4'b0000, carry};

        if (clearScore) begin
            tens_d  = 4'd0;
            units_d = 4'd0;
            max_d   = 1'b0;
        end else if (addPulse) begin
            if (tens_sum > 5'd9) begin
                tens_d  = 4'd9;
                units_d = 4'd9;
                max_d   = 1'b1;
            end else begin
                tens_d  = tens_sum[3:0];
                units_d = units_add;
            end
        end else if (subPulse) begin
            if ((tens_q != 4'd0) || (units_q != 4'd0)) begin
                if (units_q == 4'd0) begin
                    units_d = 4'd9;
                    tens_d  = tens_q - 4'd1;
                end else begin
                    units_d = units_q - 4'd1;
                end
                max_d = 1'b0;
            end
        end
    end

    // Digits follow the score only at frame start, capturing the pre-update value.
    always_comb begin
        digit1_d = digit1_q;
        digit2_d = digit2_q;
        if (startOfFrame) begin
            digit1_d = tens_q;
            digit2_d = units_q;
        end
    end

    // Box hit tests compare before subtracting so pixels left/above never underflow in.
    always_comb begin
        in_box1 = (pixelX >= X1_LO) && (pixelX < X1_HI) && (pixelY >= Y_LO) && (pixelY < Y_HI);
        in_box2 = (pixelX >= X2_LO) && (pixelX < X2_HI) && (pixelY >= Y_LO) && (pixelY < Y_HI);

`ifdef LEADING_ZERO_BLANK_EN
        flag1_d = in_box1 && (digit1_q != 4'd0);
`else
        flag1_d = in_box1;
`endif
        flag2_d = in_box2;

        ox1_d = 11'd0;
        oy1_d = 11'd0;
        ox2_d = 11'd0;
        oy2_d = 11'd0;
        if (in_box1) begin
            ox1_d = pixelX - X1_LO;
            oy1_d = pixelY - Y_LO;
        end
        if (in_box2) begin
            ox2_d = pixelX - X2_LO;
            oy2_d = pixelY - Y_LO;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tens_q   <= 4'd0;
            units_q  <= 4'd0;
            max_q    <= 1'b0;
            digit1_q <= 4'd0;
            digit2_q <= 4'd0;
            flag1_q  <= 1'b0;
            flag2_q  <= 1'b0;
            ox1_q    <= 11'd0;
            oy1_q    <= 11'd0;
            ox2_q    <= 11'd0;
            oy2_q    <= 11'd0;
        end else begin
            tens_q   <= tens_d;
            units_q  <= units_d;
            max_q    <= max_d;
            digit1_q <= digit1_d;
            digit2_q <= digit2_d;
            flag1_q  <= flag1_d;
            flag2_q  <= flag2_d;
            ox1_q    <= ox1_d;
            oy1_q    <= oy1_d;
            ox2_q    <= ox2_d;
            oy2_q    <= oy2_d;
        end
    end

    assign digit1           = digit1_q;
    assign digit2           = digit2_q;
    assign scoreMax         = max_q;
    assign InsideRectangle1 = flag1_q;
    assign InsideRectangle2 = flag2_q;
    assign offsetX1         = ox1_q;
    assign offsetY1         = oy1_q;
    assign offsetX2         = ox2_q;
    assign offsetY2         = oy2_q;

endmodule

// File: tb/tb_score_digit_driver.sv
// Self-checking bench for score_digit_driver: integer score model plus directed vectors.
module tb_score_digit_driver;

    localparam int X1 = 560;
    localparam int Y0 = 16;
    localparam int W  = 16;
    localparam int H  = 32;
    localparam int G  = 4;
    localparam int X2 = X1 + W + G;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        addPulse;
    logic [3:0]  addValue;
    logic        subPulse;
    logic        clearScore;
    logic        InsideRectangle1;
    logic        InsideRectangle2;
    logic [10:0] offsetX1;
    logic [10:0] offsetY1;
    logic [10:0] offsetX2;
    logic [10:0] offsetY2;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic        scoreMax;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    score_digit_driver #(
        .TOP_LEFT_X (X1),
        .TOP_LEFT_Y (Y0),
        .DIGIT_W    (W),
        .DIGIT_H    (H),
        .DIGIT_GAP  (G)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .pixelX           (pixelX),
        .pixelY           (pixelY),
        .addPulse         (addPulse),
        .addValue         (addValue),
        .subPulse         (subPulse),
        .clearScore       (clearScore),
        .InsideRectangle1 (InsideRectangle1),
        .InsideRectangle2 (InsideRectangle2),
        .offsetX1         (offsetX1),
        .offsetY1         (offsetY1),
        .offsetX2         (offsetX2),
        .offsetY2         (offsetY2),
        .digit1           (digit1),
        .digit2           (digit2),
        .scoreMax         (scoreMax)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: score as a plain integer 0..99; displayed value as a plain integer.
    int m_score = 0;
    bit m_max   = 0;
    int m_disp  = 0;
    bit e_f1    = 0;
    bit e_f2    = 0;
    int e_ox1   = 0;
    int e_oy1   = 0;
    int e_ox2   = 0;
    int e_oy2   = 0;
    int mv, ms, px, py;
    bit in1, in2;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_score <= 0; m_max <= 0; m_disp <= 0;
            e_f1 <= 0; e_f2 <= 0; e_ox1 <= 0; e_oy1 <= 0; e_ox2 <= 0; e_oy2 <= 0;
        end else begin
            if (startOfFrame) m_disp <= m_score;
            mv = (int'(addValue) > 9) ? 9 : int'(addValue);
            ms = m_score + mv;
            if (clearScore) begin
                m_score <= 0; m_max <= 0;
            end else if (addPulse) begin
                if (ms > 99) begin m_score <= 99; m_max <= 1; end
                else m_score <= ms;
            end else if (subPulse && m_score > 0) begin
                m_score <= m_score - 1; m_max <= 0;
            end
            px  = int'(pixelX);
            py  = int'(pixelY);
            in1 = (px >= X1) && (px < X1 + W) && (py >= Y0) && (py < Y0 + H);
            in2 = (px >= X2) && (px < X2 + W) && (py >= Y0) && (py < Y0 + H);
`ifdef LEADING_ZERO_BLANK_EN
            e_f1 <= in1 && (m_disp / 10 != 0);
`else
            e_f1 <= in1;
`endif
            e_f2  <= in2;
            e_ox1 <= in1 ? px - X1 : 0;
            e_oy1 <= in1 ? py - Y0 : 0;
            e_ox2 <= in2 ? px - X2 : 0;
            e_oy2 <= in2 ? py - Y0 : 0;
        end
    end

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("digit1",   32'(digit1),           32'(m_disp / 10));
            chk("digit2",   32'(digit2),           32'(m_disp % 10));
            chk("scoreMax", 32'(scoreMax),         32'(m_max));
            chk("flag1",    32'(InsideRectangle1), 32'(e_f1));
            chk("flag2",    32'(InsideRectangle2), 32'(e_f2));
            chk("offsetX1", 32'(offsetX1),         32'(e_ox1));
            chk("offsetY1", 32'(offsetY1),         32'(e_oy1));
            chk("offsetX2", 32'(offsetX2),         32'(e_ox2));
            chk("offsetY2", 32'(offsetY2),         32'(e_oy2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int v);
        addValue = 4'(v); addPulse = 1'b1; tick(); addPulse = 1'b0;
    endtask

    task automatic sub();
        subPulse = 1'b1; tick(); subPulse = 1'b0;
    endtask

    task automatic clr();
        clearScore = 1'b1; tick(); clearScore = 1'b0;
    endtask

    task automatic frame();
        startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        pixelX = 11'(x); pixelY = 11'(y); tick();
    endtask

    initial begin
        resetN = 1'b1; startOfFrame = 1'b0; pixelX = 11'd0; pixelY = 11'd0;
        addPulse = 1'b0; addValue = 4'd0; subPulse = 1'b0; clearScore = 1'b0;
        #2 resetN = 1'b0;
        #20;
        cmp_en = 1'b1;
        tick();
        resetN = 1'b1;
        tick();

        // Reach 47, display it, then reset mid-frame with the pixel inside box1.
        for (int i = 0; i < 5; i++) add(9);
        add(2);
        frame();
        chk("lit_d1_47", 32'(digit1), 32'd4);
        chk("lit_d2_47", 32'(digit2), 32'd7);
        pix(565, 20);
        #2 resetN = 1'b0;
        #1;
        chk("lit_rst_d1", 32'(digit1), 32'd0);
        chk("lit_rst_d2", 32'(digit2), 32'd0);
        chk("lit_rst_max", 32'(scoreMax), 32'd0);
        chk("lit_rst_f1", 32'(InsideRectangle1), 32'd0);
        chk("lit_rst_ox1", 32'(offsetX1), 32'd0);
        tick();
        resetN = 1'b1;
        pix(0, 0);

        // 08 + 5 -> 13
        add(8);
        add(5);
        frame();
        chk("lit_d1_13", 32'(digit1), 32'd1);
        chk("lit_d2_13", 32'(digit2), 32'd3);
        chk("lit_model_13", 32'(m_disp), 32'd13);

        // 95 + 9 saturates at 99, then a sub clears scoreMax.
        clr();
        for (int i = 0; i < 10; i++) add(9);
        add(5);
        add(9);
        chk("lit_max_set", 32'(scoreMax), 32'd1);
        chk("lit_model_99", 32'(m_score), 32'd99);
        sub();
        chk("lit_max_clr", 32'(scoreMax), 32'd0);
        frame();
        chk("lit_d1_98", 32'(digit1), 32'd9);
        chk("lit_d2_98", 32'(digit2), 32'd8);

        // Sub at 00 holds; 10 - 1 borrows to 09; add beats sub; addValue clamps to 9.
        clr();
        sub();
        frame();
        chk("lit_d2_00", 32'(digit2), 32'd0);
        add(9);
        add(1);
        sub();
        frame();
        chk("lit_d1_09", 32'(digit1), 32'd0);
        chk("lit_d2_09", 32'(digit2), 32'd9);
        addValue = 4'd2; addPulse = 1'b1; subPulse = 1'b1; tick();
        addPulse = 1'b0; subPulse = 1'b0;
        frame();
        chk("lit_d1_11", 32'(digit1), 32'd1);
        chk("lit_d2_11", 32'(digit2), 32'd1);
        clr();
        add(15);
        frame();
        chk("lit_clamp", 32'(digit2), 32'd9);
        add(2);
        frame();  // shows 11 so leading-zero blanking does not hide box1 below

        // Geometry sweep along y = 16.
        pix(559, 16);
        chk("lit_f1_559", 32'(InsideRectangle1), 32'd0);
        pix(560, 16);
        chk("lit_f1_560", 32'(InsideRectangle1), 32'd1);
        chk("lit_ox1_560", 32'(offsetX1), 32'd0);
        pix(575, 16);
        chk("lit_f1_575", 32'(InsideRectangle1), 32'd1);
        chk("lit_ox1_575", 32'(offsetX1), 32'd15);
        pix(576, 16);
        chk("lit_f1_576", 32'(InsideRectangle1), 32'd0);
        chk("lit_f2_576", 32'(InsideRectangle2), 32'd0);
        pix(580, 16);
        chk("lit_f2_580", 32'(InsideRectangle2), 32'd1);
        chk("lit_ox2_580", 32'(offsetX2), 32'd0);
        pix(595, 47);
        chk("lit_ox2_595", 32'(offsetX2), 32'd15);
        chk("lit_oy2_47", 32'(offsetY2), 32'd31);
        pix(596, 47);
        chk("lit_f2_596", 32'(InsideRectangle2), 32'd0);
        pix(565, 48);
        chk("lit_f1_y48", 32'(InsideRectangle1), 32'd0);
        pix(565, 15);
        chk("lit_f1_y15", 32'(InsideRectangle1), 32'd0);
        pix(0, 0);

        // Update in the same cycle as startOfFrame: display keeps the old 11.
        addValue = 4'd3; addPulse = 1'b1; startOfFrame = 1'b1; tick();
        addPulse = 1'b0; startOfFrame = 1'b0;
        chk("lit_tear_d2", 32'(digit2), 32'd1);
        tick();
        frame();
        chk("lit_next_d2", 32'(digit2), 32'd4);

        // Score 07 displayed; box1 pixel behaviour depends on leading-zero blanking.
        clr();
        add(7);
        frame();
        pix(565, 20);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lit_blank_f1", 32'(InsideRectangle1), 32'd0);
`else
        chk("lit_zero_f1", 32'(InsideRectangle1), 32'd1);
`endif
        chk("lit_zero_ox1", 32'(offsetX1), 32'd5);
        chk("lit_zero_oy1", 32'(offsetY1), 32'd4);
        pix(0, 0);
        tick();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
